// File: rtl/controla_entrada.sv
// Input-confirm stage: arms on a CPU WAIT pulse, captures the switch word on a debounced button press, pulses READY.
// Optional ARMED timeout under `define CONTROLA_ENTRADA_TIMEOUT_EN.
module controla_entrada #(
  parameter int DATA_W          = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16,
  parameter int TIMEOUT_CYCLES  = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WAIT,
  input  logic [DATA_W-1:0] sw_in,
  input  logic              btn_confirm,
  output logic              READY,
  output logic [DATA_W-1:0] in_data,
  output logic              waiting,
  output logic              timeout
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic              btn_s1_q, btn_s2_q;
  logic [DATA_W-1:0] sw_s1_q, sw_s2_q;
  logic              btn_db_q, btn_db_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        state_q, state_d;
  logic              pending_q, pending_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] in_data_q, in_data_d;
  logic              waiting_q, waiting_d;
  logic              press_s, release_s;
  logic              timeout_hit_s, timeout_set_s;

  // Two-flop synchronisers for the raw button and switch word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      btn_s1_q <= btn_confirm;
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= sw_in;
      sw_s2_q  <= sw_s1_q;
    end
  end

  // Debounce: accept a level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    cnt_d    = cnt_q;
    btn_db_d = btn_db_q;
    if (btn_s2_q == btn_db_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_MAX) begin
      btn_db_d = btn_s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign press_s   = ~btn_db_q &  btn_db_d;
  assign release_s =  btn_db_q & ~btn_db_d;

  // Next-state logic; a press wins over a timeout expiring on the same edge.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    ready_d       = 1'b0;
    in_data_d     = in_data_q;
    timeout_set_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (WAIT) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (press_s) begin
          ready_d   = 1'b1;
          in_data_d = sw_s2_q;
          state_d   = ST_RELEASE;
        end else if (timeout_hit_s) begin
          ready_d       = 1'b1;
          in_data_d     = '0;
          timeout_set_s = 1'b1;
          state_d       = btn_db_d ? ST_RELEASE : ST_IDLE;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_RELEASE: begin
        if (release_s) begin
          pending_d = 1'b0;
          state_d   = (pending_q | WAIT) ? ST_ARMED : ST_IDLE;
        end else if (WAIT) begin
          pending_d = 1'b1;
        end else begin
          pending_d = pending_q;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        pending_d = 1'b0;
      end
    endcase
    waiting_d = (state_d == ST_ARMED);
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_db_q  <= 1'b0;
      cnt_q     <= '0;
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      ready_q   <= 1'b0;
      in_data_q <= '0;
      waiting_q <= 1'b0;
    end else begin
      btn_db_q  <= btn_db_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      in_data_q <= in_data_d;
      waiting_q <= waiting_d;
    end
  end

`ifdef CONTROLA_ENTRADA_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             timeout_q, timeout_d;

  assign timeout_hit_s = (tcnt_q == TO_MAX);

  // Timeout counter restarts from 0 on every entry into ARMED.
  always_comb begin
    if ((state_q == ST_ARMED) && (state_d == ST_ARMED)) begin
      tcnt_d = tcnt_q + CNT_W'(1);
    end else begin
      tcnt_d = '0;
    end
    if (timeout_set_s) begin
      timeout_d = 1'b1;
    end else if (WAIT) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end
  end

  // Timeout state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout_hit_s = 1'b0;
  assign timeout       = 1'b0;
`endif

  assign READY   = ready_q;
  assign in_data = in_data_q;
  assign waiting = waiting_q;

endmodule

// File: tb/tb_controla_entrada.sv
// Scoreboard bench for controla_entrada: expected READY cycle and data are queued at stimulus time.
module tb_controla_entrada;

  localparam int DW = 16;
  localparam int DB = 4;
  localparam int TO = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          WAIT;
  logic [DW-1:0] sw;
  logic          btn;
  logic          READY;
  logic [DW-1:0] in_data;
  logic          waiting;
  logic          timeout;

  controla_entrada #(
    .DATA_W(DW), .DEBOUNCE_CYCLES(DB), .CNT_W(16), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .WAIT(WAIT), .sw_in(sw), .btn_confirm(btn),
    .READY(READY), .in_data(in_data), .waiting(waiting), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Every READY cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && READY) begin
      if (sb.size() == 0) begin
        check_eq("ready_unexpected", {31'd0, READY}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("ready_cycle", cyc, e.cyc);
        check_eq("ready_data", {16'd0, in_data}, {16'd0, e.data});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_wait(output int c);
    @(negedge clk);
    WAIT = 1'b1;
    c = cyc;
    @(negedge clk);
    WAIT = 1'b0;
  endtask

  task automatic press_expect(input logic [DW-1:0] d);
    exp_t e;
    @(negedge clk);
    btn = 1'b1;
    e.cyc  = cyc + DB + 2;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic release_btn();
    @(negedge clk);
    btn = 1'b0;
  endtask

  int c0;

  initial begin
    reset = 1'b1;
    WAIT  = 1'b0;
    sw    = 16'h0000;
    btn   = 1'b0;
    tick(3);
    check_eq("rst_ready", {31'd0, READY}, 32'd0);
    check_eq("rst_in_data", {16'd0, in_data}, 32'd0);
    check_eq("rst_waiting", {31'd0, waiting}, 32'd0);
    check_eq("rst_timeout", {31'd0, timeout}, 32'd0);
    reset = 1'b0;
    tick(2);

    // Press in IDLE, no WAIT: nothing happens
    sw  = 16'hBEEF;
    @(negedge clk);
    btn = 1'b1;
    tick(20);
    check_eq("idle_in_data", {16'd0, in_data}, 32'd0);
    check_eq("idle_waiting", {31'd0, waiting}, 32'd0);
    release_btn();
    tick(DB + 4);

    // Clean press
    sw = 16'hA5C3;
    pulse_wait(c0);
    check_eq("arm_waiting", {31'd0, waiting}, 32'd1);
    tick(3);
    press_expect(16'hA5C3);
    tick(DB + 1);
    check_eq("pre_ready_waiting", {31'd0, waiting}, 32'd1);
    tick(1);
    check_eq("ready_edge_waiting", {31'd0, waiting}, 32'd0);
    tick(4);
    check_eq("hold_in_data", {16'd0, in_data}, 32'h0000A5C3);
    release_btn();
    tick(DB + 4);
    check_eq("after_rel_waiting", {31'd0, waiting}, 32'd0);

    // Bouncy press
    sw = 16'h1234;
    pulse_wait(c0);
    tick(2);
    @(negedge clk); btn = 1'b1;
    @(negedge clk); btn = 1'b0;
    @(negedge clk); btn = 1'b1;
    @(negedge clk); btn = 1'b0;
    press_expect(16'h1234);
    tick(DB + 8);
    check_eq("bounce_in_data", {16'd0, in_data}, 32'h00001234);
    release_btn();
    tick(DB + 4);

    // Button held across WAIT: no press event until release and re-press
    @(negedge clk); btn = 1'b1;
    tick(DB + 4);
    sw = 16'h0F0F;
    pulse_wait(c0);
    tick(10);
    check_eq("held_waiting", {31'd0, waiting}, 32'd1);
    release_btn();
    tick(DB + 4);
    check_eq("held_rel_waiting", {31'd0, waiting}, 32'd1);
    press_expect(16'h0F0F);
    tick(DB + 8);

    // WAIT during RELEASE sets pending; release re-arms
    sw = 16'h3C3C;
    pulse_wait(c0);
    check_eq("rel_wait_waiting", {31'd0, waiting}, 32'd0);
    tick(3);
    release_btn();
    tick(DB + 4);
    check_eq("pending_rearm", {31'd0, waiting}, 32'd1);
    press_expect(16'h3C3C);
    tick(DB + 8);
    release_btn();
    tick(DB + 4);
    check_eq("pending_done_idle", {31'd0, waiting}, 32'd0);

    // Reset while ARMED
    pulse_wait(c0);
    check_eq("pre_rst_waiting", {31'd0, waiting}, 32'd1);
    tick(2);
    reset = 1'b1;
    #1;
    check_eq("midrst_waiting", {31'd0, waiting}, 32'd0);
    check_eq("midrst_ready", {31'd0, READY}, 32'd0);
    check_eq("midrst_in_data", {16'd0, in_data}, 32'd0);
    tick(2);
    reset = 1'b0;
    tick(2);

`ifdef CONTROLA_ENTRADA_TIMEOUT_EN
    begin
      exp_t e;
      sw = 16'h5555;
      pulse_wait(c0);
      e.cyc  = c0 + TO + 1;
      e.data = 16'h0000;
      sb.push_back(e);
      tick(TO + 4);
      check_eq("to_flag", {31'd0, timeout}, 32'd1);
      check_eq("to_in_data", {16'd0, in_data}, 32'd0);
      check_eq("to_waiting", {31'd0, waiting}, 32'd0);
      pulse_wait(c0);
      check_eq("to_clear", {31'd0, timeout}, 32'd0);
      check_eq("to_rearm", {31'd0, waiting}, 32'd1);
      press_expect(16'h5555);
      tick(DB + 8);
      release_btn();
      tick(DB + 4);
    end
`else
    sw = 16'h5555;
    pulse_wait(c0);
    tick(40);
    check_eq("noto_waiting", {31'd0, waiting}, 32'd1);
    check_eq("noto_flag", {31'd0, timeout}, 32'd0);
    press_expect(16'h5555);
    tick(DB + 8);
    release_btn();
    tick(DB + 4);
`endif

    tick(5);
    check_eq("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controla_entrada.md
Name: controla_entrada

Overview:
- Upstream stage of the OS/BIOS controller; produces its READY input.
- When the CPU executes an input instruction (WAIT pulse), the block arms itself and waits for the user to press a confirm button.
- On a debounced press it latches the switch word into in_data and pulses READY for one cycle.
- It then waits for a debounced button release before re-arming.

Parameters:
- DATA_W, 16, width of switch input and latched data.
- DEBOUNCE_CYCLES, 1000, consecutive stable cycles required to accept a button level change (minimum 2).
- CNT_W, 16, width of the debounce and timeout counters; must hold DEBOUNCE_CYCLES and TIMEOUT_CYCLES.
- TIMEOUT_CYCLES, 50000, ARMED timeout; used only with CONTROLA_ENTRADA_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- WAIT  input  1  one-cycle pulse from the CPU input instruction
- sw_in  input  DATA_W  raw switch word, asynchronous
- btn_confirm  input  1  raw confirm button, active-high, asynchronous, bouncy
- READY  output  1  one-cycle pulse: input confirmed
- in_data  output  DATA_W  latched switch word, valid from the READY cycle until the next capture
- waiting  output  1  high while ARMED (LED "waiting for input")
- timeout  output  1  sticky timeout flag; constant 0 when the feature is absent

Behaviour:
- Reset (asynchronous): state IDLE; READY=0, in_data=0, waiting=0, timeout=0; sync flops, btn_db, counters and pending all 0.
- Synchronisers: btn_confirm and sw_in each pass through 2 flops (s1, s2).
- Debounce counter cnt:
  - When s2 == btn_db, cnt is cleared to 0.
  - When s2 != btn_db and cnt < DEBOUNCE_CYCLES-1, cnt increments.
  - When s2 != btn_db and cnt == DEBOUNCE_CYCLES-1, btn_db <= s2 and cnt <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes btn_db.
- Press event: the clock edge on which btn_db goes 0->1. Release event: the edge on which btn_db goes 1->0.
- FSM states:
  - IDLE: on WAIT=1, go to ARMED. Presses are ignored.
  - ARMED: waiting=1. On a press event in the same edge: READY<=1, in_data<=sw s2, go to RELEASE. WAIT here is ignored (no double arm).
  - RELEASE:
    - On a release event with pending=1: clear pending, go to ARMED.
    - On a release event with pending=0: go to IDLE.
    - WAIT=1 in RELEASE sets pending.
- READY is high for exactly one cycle per press event in ARMED. It is never asserted in IDLE or RELEASE.
- Latency: with raw btn stable 1 from before edge k, READY is high after edge k+DEBOUNCE_CYCLES+1 (DEBOUNCE_CYCLES+2 edges).
- Button already held when WAIT arrives: btn_db is already 1, so there is no press event. The user must release and press again.
- Simultaneous WAIT and press event while in IDLE: the transition to ARMED happens; the press is not accepted.
- Reset mid-operation (ARMED/RELEASE): return to IDLE immediately, no READY, in_data cleared.
- in_data never changes except at a capture, at a timeout, or at reset.

Optional Feature:
- Macro CONTROLA_ENTRADA_TIMEOUT_EN.
- Defined:
  - A counter runs in ARMED, starting at 0 on entry.
  - When it reaches TIMEOUT_CYCLES-1 without a press: READY<=1 for one cycle, in_data<=0, timeout<=1, go to RELEASE if btn_db=1, otherwise IDLE.
  - timeout clears on the next WAIT or on reset.
- Undefined: no counter; ARMED waits forever; timeout tied to 0.

Test Plan:
- DEBOUNCE_CYCLES=4. Reset, WAIT pulse, sw_in=16'hA5C3, btn rises cleanly at edge k -> READY=1 for exactly one cycle after edge k+5; in_data=16'hA5C3; waiting 1->0 at the same edge.
- Bounce: btn toggles 1,0,1,0 each cycle, then stays 1 -> single READY pulse, 5 edges after the final stable rise; no extra pulses.
- Press in IDLE (no WAIT), held 20 cycles -> READY stays 0, in_data unchanged (0).
- Button held across a WAIT pulse -> no READY; release, then press -> one READY with the current sw_in.
- WAIT pulse during RELEASE (button held), then release -> waiting=1 after the release event; the next press gives READY. Reset asserted while ARMED -> waiting=0, READY=0, in_data=0.
- With CONTROLA_ENTRADA_TIMEOUT_EN, TIMEOUT_CYCLES=10, WAIT, no press -> READY pulse 10 cycles after entry, in_data=0, timeout=1; the next WAIT clears timeout.
